// File: rtl/reg_block.sv
// Datapath register block: 2^RWIDTH x DWIDTH register file (R0 = 0), immediate
// sign-extender, operand-B mux and 4-bit ALU. Define REGBLOCK_BYPASS_EN for write-first read forwarding.
module reg_block #(
    parameter int RWIDTH = 6,
    parameter int DWIDTH = 32,
    parameter int IMM_IN = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RWIDTH-1:0] rs,
    input  logic [RWIDTH-1:0] rt,
    input  logic [RWIDTH-1:0] rd,
    input  logic [DWIDTH-1:0] wd,
    input  logic              we,
    input  logic              muxsel1,
    input  logic [IMM_IN-1:0] imm_in,
    input  logic [3:0]        ALUopsel,
    output logic [DWIDTH-1:0] opBwd,
    output logic [DWIDTH-1:0] ALUresult
);

    localparam int NREG = 1 << RWIDTH;
    localparam int SHW  = $clog2(DWIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_PASS = 4'b1011;

    logic [DWIDTH-1:0] rf [NREG];

    assign rf[0] = '0;

    // Flop-based storage: asynchronous clear of every entry rules out a RAM macro.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            logic [DWIDTH-1:0] reg_d;
            logic [DWIDTH-1:0] reg_q;

            always_comb begin
                reg_d = reg_q;
                if (we && (rd == RWIDTH'(gi))) begin
                    reg_d = wd;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign rf[gi] = reg_q;
        end
    endgenerate

    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b_reg;
    logic [DWIDTH-1:0] ext_imm;
    logic [DWIDTH-1:0] op_b;
    logic [SHW-1:0]    shamt;
    logic [DWIDTH-1:0] alu_result;

    always_comb begin
        op_a     = rf[rs];
        op_b_reg = rf[rt];
`ifdef REGBLOCK_BYPASS_EN
        // Forward the in-flight write so a dependent read sees it before the edge.
        if (!rst && we && (rd != '0)) begin
            if (rs == rd) begin
                op_a = wd;
            end
            if (rt == rd) begin
                op_b_reg = wd;
            end
        end
`endif
    end

    assign ext_imm = {{(DWIDTH - IMM_IN){imm_in[IMM_IN-1]}}, imm_in};
    assign op_b    = muxsel1 ? ext_imm : op_b_reg;
    assign shamt   = op_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (ALUopsel)
            OP_ADD:  alu_result = op_a + op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_NOR:  alu_result = ~(op_a | op_b);
            OP_SLL:  alu_result = op_a << shamt;
            OP_SRL:  alu_result = op_a >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:  alu_result = {{(DWIDTH - 1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_result = {{(DWIDTH - 1){1'b0}}, (op_a < op_b)};
            OP_PASS: alu_result = op_b;
            default: alu_result = '0;
        endcase
    end

    assign opBwd     = op_b_reg;
    assign ALUresult = alu_result;

endmodule

// File: tb/tb_reg_block.sv
// Scoreboard bench for reg_block: stimulus pushes expected results computed from an
// array model of the register file; a negedge monitor pops and compares.
module tb_reg_block;

    logic        clk;
    logic        rst;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic [31:0] wd;
    logic        we;
    logic        muxsel1;
    logic [14:0] imm_in;
    logic [3:0]  ALUopsel;
    logic [31:0] opBwd;
    logic [31:0] ALUresult;

    reg_block #(.RWIDTH(6), .DWIDTH(32), .IMM_IN(15)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd(rd), .wd(wd), .we(we),
        .muxsel1(muxsel1), .imm_in(imm_in), .ALUopsel(ALUopsel),
        .opBwd(opBwd), .ALUresult(ALUresult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] opb;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [64];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0]  s;
        logic [63:0] wide;
        s = b[4:0];
        case (op)
            4'd0: begin wide = {32'd0, a} + {32'd0, b}; return wide[31:0]; end
            4'd1: return a & b;
            4'd2: return a | b;
            4'd3: begin wide = {32'd0, a} + {32'd0, ~b} + 64'd1; return wide[31:0]; end
            4'd4: return a ^ b;
            4'd5: return ~(a | b);
            4'd6: begin wide = {32'd0, a} * (64'd1 << s); return wide[31:0]; end
            4'd7: return a / (32'd1 << s);
            4'd8: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd9: begin
                if (a[31] != b[31]) return a[31] ? 32'd1 : 32'd0;
                return (a < b) ? 32'd1 : 32'd0;
            end
            4'd10: return (a < b) ? 32'd1 : 32'd0;
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Value a read port should show given the currently driven inputs.
    function automatic logic [31:0] read_model(input logic [5:0] addr);
        if (addr == 6'd0 || rst) return 32'd0;
`ifdef REGBLOCK_BYPASS_EN
        if (we && rd != 6'd0 && addr == rd) return wd;
`endif
        return model[addr];
    endfunction

    task automatic apply(input string name, input logic we_i, input logic [5:0] rd_i,
                         input logic [31:0] wd_i, input logic [5:0] rs_i, input logic [5:0] rt_i,
                         input logic mux_i, input logic [14:0] imm_i, input logic [3:0] op_i);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] breg;
        we = we_i; rd = rd_i; wd = wd_i; rs = rs_i; rt = rt_i;
        muxsel1 = mux_i; imm_in = imm_i; ALUopsel = op_i;
        a    = read_model(rs_i);
        breg = read_model(rt_i);
        b    = mux_i ? {{17{imm_i[14]}}, imm_i} : breg;
        e.name = name;
        e.alu  = alu_model(op_i, a, b);
        e.opb  = breg;
        exp_q.push_back(e);
    endtask

    // Advance one rising edge, committing the write the model expects there.
    task automatic tick();
        @(posedge clk);
        if (!rst && we && rd != 6'd0) model[rd] = wd;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 2;
                if (ALUresult !== e.alu) begin
                    errors++;
                    $display("FAIL %s ALUresult got=%08h exp=%08h", e.name, ALUresult, e.alu);
                end
                if (opBwd !== e.opb) begin
                    errors++;
                    $display("FAIL %s opBwd got=%08h exp=%08h", e.name, opBwd, e.opb);
                end
                $display("chk %s alu=%08h opb=%08h", e.name, ALUresult, opBwd);
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        rst = 1'b1; we = 1'b0; rd = '0; wd = '0; rs = '0; rt = '0;
        muxsel1 = 1'b0; imm_in = '0; ALUopsel = '0;
        repeat (2) @(posedge clk);
        #1;
        apply("rst_op15", 1'b0, 6'd0, 32'd0, 6'd3, 6'd5, 1'b0, 15'h0000, 4'b1111);
        tick();
        apply("rst_passimm", 1'b0, 6'd0, 32'd0, 6'd3, 6'd5, 1'b1, 15'h0123, 4'b1011);
        tick();
        rst = 1'b0;

        apply("wr7", 1'b1, 6'd7, 32'h0000_AAAA, 6'd1, 6'd2, 1'b0, 15'h0, 4'd0);
        tick();
        apply("wr56", 1'b1, 6'd56, 32'hBBBB_0000, 6'd1, 6'd2, 1'b0, 15'h0, 4'd0);
        tick();
        apply("add_7_56", 1'b0, 6'd0, 32'd0, 6'd7, 6'd56, 1'b0, 15'h0, 4'b0000);
        tick();
        apply("wr63", 1'b1, 6'd63, 32'hEEEE_EEEE, 6'd7, 6'd56, 1'b0, 15'h0, 4'b0000);
        tick();
        apply("rd63", 1'b0, 6'd0, 32'd0, 6'd7, 6'd63, 1'b0, 15'h0, 4'b1011);
        tick();
        apply("sub_imm", 1'b0, 6'd0, 32'd0, 6'd7, 6'd63, 1'b1, 15'h0AA9, 4'b0011);
        tick();
        apply("add_imm", 1'b0, 6'd0, 32'd0, 6'd56, 6'd63, 1'b1, 15'h0AA9, 4'b0000);
        tick();
        apply("add_negimm", 1'b0, 6'd0, 32'd0, 6'd56, 6'd63, 1'b1, 15'h7FFF, 4'b0000);
        tick();
        apply("wr0", 1'b1, 6'd0, 32'h1234_5678, 6'd56, 6'd63, 1'b0, 15'h0, 4'd0);
        tick();
        apply("r0_pass", 1'b0, 6'd0, 32'd0, 6'd0, 6'd0, 1'b0, 15'h0, 4'b1011);
        tick();
        apply("pre_rst", 1'b0, 6'd0, 32'd0, 6'd7, 6'd7, 1'b0, 15'h0, 4'b0000);
        tick();
        // Reset raised between edges; the monitor samples before the next edge.
        rst = 1'b1;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        apply("async_rst_rt7", 1'b0, 6'd0, 32'd0, 6'd7, 6'd7, 1'b0, 15'h0, 4'b0000);
        #2;
        apply("async_rst_add", 1'b0, 6'd0, 32'd0, 6'd7, 6'd56, 1'b0, 15'h0, 4'b0000);
        tick();
        apply("rst_wr_blocked", 1'b1, 6'd12, 32'hDEAD_BEEF, 6'd12, 6'd12, 1'b0, 15'h0, 4'd0);
        tick();
        rst = 1'b0;
        apply("after_rst_r12", 1'b0, 6'd0, 32'd0, 6'd12, 6'd12, 1'b0, 15'h0, 4'b0000);
        tick();
        apply("rdw_before", 1'b1, 6'd9, 32'h0000_0005, 6'd9, 6'd9, 1'b1, 15'h0, 4'b0000);
        tick();
        apply("rdw_after", 1'b0, 6'd0, 32'd0, 6'd9, 6'd9, 1'b1, 15'h0, 4'b0000);
        tick();

        for (int n = 0; n < 400; n++) begin
            logic [5:0]  r_rd;
            logic [5:0]  r_rs;
            logic [5:0]  r_rt;
            logic [31:0] r_wd;
            r_rd = 6'($urandom_range(0, 63));
            r_rs = ($urandom_range(0, 3) == 0) ? r_rd : 6'($urandom_range(0, 63));
            r_rt = ($urandom_range(0, 3) == 0) ? r_rd : 6'($urandom_range(0, 63));
            r_wd = ($urandom_range(0, 3) == 0) ? 32'(32'h8000_0000 | $urandom_range(0, 63))
                                               : $urandom;
            apply($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), r_rd, r_wd, r_rs, r_rt,
                  1'($urandom_range(0, 1)), 15'($urandom), 4'($urandom_range(0, 15)));
            tick();
        end

        we = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_block.md
# reg_block

Datapath register block for the 32-bit processor. It combines a 64-entry × 32-bit register file with an immediate extender, an operand-B multiplexer and a 4-bit-opcode ALU, producing one ALU result per instruction. It sits between the controller/decoder, which drives addresses, select and opcode, and the memory/write-back stage, which consumes `ALUresult` and `opBwd`.

## Interface
- `RWIDTH`, 6: register address width (2^RWIDTH entries).
- `DWIDTH`, 32: data width.
- `IMM_IN`, 15: immediate field width.

Ports:
- `clk` in 1: clock. One clock; all writes occur on the rising edge.
- `rst` in 1: reset, asynchronous, active-high. Clears every register to 0.
- `rs` in RWIDTH: read address for operand A.
- `rt` in RWIDTH: read address for operand B / store data.
- `rd` in RWIDTH: write address.
- `wd` in DWIDTH: write data.
- `we` in 1: write enable.
- `muxsel1` in 1: operand-B select. 0 selects R[rt]; 1 selects the extended immediate.
- `imm_in` in IMM_IN: immediate field.
- `ALUopsel` in 4: ALU operation.
- `opBwd` out DWIDTH: R[rt], unmuxed (store write data).
- `ALUresult` out DWIDTH: ALU output.

## Operation
- Register file:
  - 64 × 32 bits.
  - R0 is hardwired to 0. Writes to R0 are ignored.
  - Reads are combinational: opA = R[rs], opBwd = R[rt].
- Immediate: `imm_in` is sign-extended from bit 14 to 32 bits.
- Operand B: `muxsel1 ? ext_imm : R[rt]`.
- ALU (combinational). Arithmetic wraps modulo 2^32 and no flags are produced.
  - 0000 ADD
  - 0001 AND
  - 0010 OR
  - 0011 SUB (A−B)
  - 0100 XOR
  - 0101 NOR
  - 0110 SLL A by B[4:0]
  - 0111 SRL
  - 1000 SRA
  - 1001 SLT signed (result 1/0)
  - 1010 SLTU
  - 1011 pass B
  - 1100–1111: result 0
- Write: R[rd] ← wd at the rising `clk` edge when `we`=1, `rst`=0 and rd≠0.

## Timing
- Write latency is one edge. A value written at edge N is visible on the read outputs combinationally just after edge N.
- Read-during-write to the same address in the same cycle returns the old value until the edge (no bypass unless configured).
- `rst` asserted mid-cycle clears all registers immediately, with no clock needed. While `rst`=1, writes are blocked.
- Output values during and after reset:
  - `opBwd` = 0.
  - `ALUresult` is purely combinational from zero registers, the immediate and the opcode. For example, with `ALUopsel`=1111 it is 0.
- The same edge with `we`=1 and `rst` deasserting: the write is taken only if `rst` is low at the edge.

## Configuration
- `REGBLOCK_BYPASS_EN`:
  - Defined: when `we`=1 and rd≠0, a read address equal to rd returns `wd` combinationally (write-first forwarding). This applies to opA, to opBwd and to the operand-B path.
  - Undefined: reads always return the stored array contents (old value).

## Test plan
- Reset, then `we`=1, rd=7, wd=0x0000AAAA for one edge; then rd=56, wd=0xBBBB0000 for one edge. Then `we`=0, rs=7, rt=56, `muxsel1`=0, op=0000 -> `ALUresult`=0xBBBBAAAA and `opBwd`=0xBBBB0000.
- Write rd=63, wd=0xEEEEEEEE -> with rt=63, `opBwd`=0xEEEEEEEE. Then rs=7, rt=63, `muxsel1`=1, op=0011, imm=0x0AA9 -> `ALUresult`=0x0000A001 and `opBwd`=0xEEEEEEEE.
- rs=56, `muxsel1`=1, op=0000, imm=0x0AA9 -> 0xBBBB0AA9. With imm=0x7FFF (sign-extends to −1) -> 0xBBBAFFFF.
- Write rd=0, wd=0x12345678 -> rs=0, op=1011 with rt=0, `muxsel1`=0 -> `ALUresult`=0; `opBwd`=0.
- Assert `rst` asynchronously between edges after the writes above -> `opBwd` for rt=7 reads 0 immediately. `ALUresult` for ADD rs=7, rt=56 is 0.
- `we`=1, rd=rs=9, wd=0x5 in one cycle -> before the edge, opA reads the old value (0), or 0x5 with `REGBLOCK_BYPASS_EN` defined; after the edge it reads 0x5.
